// File: rtl/axi_lite_master_bridge.sv
// Bridges single-outstanding core requests from the cache miss/writeback path
// onto an AXI4-Lite master port, returning a one-cycle core response pulse.
module axi_lite_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req_valid,
  output logic                    core_req_ready,
  input  logic                    core_req_we,
  input  logic [ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [DATA_WIDTH-1:0]   core_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] core_req_wstrb,
  output logic                    core_resp_valid,
  output logic                    core_resp_is_write,
  output logic [DATA_WIDTH-1:0]   core_resp_rdata,
  output logic [1:0]              core_resp_resp,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [2:0]              dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_ADDR = 3'd1,
    S_W_RESP = 3'd2,
    S_R_ADDR = 3'd3,
    S_R_DATA = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_resp_valid;
  logic                  r_resp_is_write;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic [1:0]            r_resp_resp;

  logic                  w_aw_done_nxt;
  logic                  w_w_done_nxt;

  // AW and W complete independently; the write phase ends once both have
  // handshaken, whether in the same cycle or in either order.
  assign w_aw_done_nxt = r_aw_done | (r_awvalid & m_awready);
  assign w_w_done_nxt  = r_w_done  | (r_wvalid  & m_wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_req_ready     <= 1'b1;
      r_awvalid       <= 1'b0;
      r_wvalid        <= 1'b0;
      r_bready        <= 1'b0;
      r_arvalid       <= 1'b0;
      r_rready        <= 1'b0;
      r_aw_done       <= 1'b0;
      r_w_done        <= 1'b0;
      r_awaddr        <= '0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_araddr        <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_is_write <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_resp     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (core_req_valid) begin
            r_req_ready <= 1'b0;
            if (core_req_we) begin
              r_awaddr  <= core_req_addr;
              r_wdata   <= core_req_wdata;
              r_wstrb   <= core_req_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_W_ADDR;
            end else begin
              r_araddr  <= core_req_addr;
              r_arvalid <= 1'b1;
              r_state   <= S_R_ADDR;
            end
          end
        end
        S_W_ADDR: begin
          if (r_awvalid && m_awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && m_wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_done_nxt && w_w_done_nxt) begin
            r_bready <= 1'b1;
            r_state  <= S_W_RESP;
          end
        end
        S_W_RESP: begin
          if (m_bvalid) begin
            r_bready        <= 1'b0;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_resp_resp     <= m_bresp;
            r_resp_is_write <= 1'b1;
            r_resp_rdata    <= '0;
            r_resp_valid    <= 1'b1;
            r_state         <= S_RESP;
          end
        end
        S_R_ADDR: begin
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R_DATA;
          end
        end
        S_R_DATA: begin
          if (m_rvalid) begin
            r_rready        <= 1'b0;
            r_resp_rdata    <= m_rdata;
            r_resp_resp     <= m_rresp;
            r_resp_is_write <= 1'b0;
            r_resp_valid    <= 1'b1;
            r_state         <= S_RESP;
          end
        end
        S_RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_aw_done   <= 1'b0;
          r_w_done    <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign core_req_ready     = r_req_ready;
  // A reset arriving during the RESP cycle must swallow the pulse already registered.
  assign core_resp_valid    = r_resp_valid & ~rst;
  assign core_resp_is_write = r_resp_is_write;
  assign core_resp_rdata    = r_resp_rdata;
  assign core_resp_resp     = r_resp_resp;

  assign m_awaddr  = r_awaddr;
  assign m_awprot  = 3'b000;
  assign m_awvalid = r_awvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_araddr  = r_araddr;
  assign m_arprot  = 3'b000;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Scoreboard bench for axi_lite_master_bridge: directed requests push expected
// core responses; a negedge monitor pops and compares each response pulse.
module tb_axi_lite_master_bridge;

  typedef struct packed {
    logic        is_write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        core_req_valid;
  logic        core_req_ready;
  logic        core_req_we;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_wdata;
  logic [3:0]  core_req_wstrb;
  logic        core_resp_valid;
  logic        core_resp_is_write;
  logic [31:0] core_resp_rdata;
  logic [1:0]  core_resp_resp;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [2:0]  dbg_state;

  axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_req_wstrb(core_req_wstrb),
    .core_resp_valid(core_resp_valid), .core_resp_is_write(core_resp_is_write),
    .core_resp_rdata(core_resp_rdata), .core_resp_resp(core_resp_resp),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  resp_t exp_q[$];

  int          cfg_aw_wait = 0;
  int          cfg_w_wait  = 0;
  int          cfg_ar_wait = 0;
  logic        cfg_b_hold  = 1'b0;
  logic [1:0]  cfg_bresp   = 2'b00;
  logic [1:0]  cfg_rresp   = 2'b00;
  logic [31:0] cfg_rdata   = 32'h0;

  localparam logic [2:0] EXP_TR  [9] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd0, 3'd3, 3'd4, 3'd5, 3'd0};
  localparam logic       EXP_RDY [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (core_resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got pulse is_write=%0b resp=%0d, expected none",
                 core_resp_is_write, core_resp_resp);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_is_write", 64'(core_resp_is_write), 64'(e.is_write));
        chk("resp_rdata",    64'(core_resp_rdata),    64'(e.rdata));
        chk("resp_resp",     64'(core_resp_resp),     64'(e.resp));
      end
    end
  end

  // AXI slave model with protocol checks against the previous cycle
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic        prev_rst = 1'b1;
  logic        prev_awvalid = 1'b0, prev_awready = 1'b0;
  logic        prev_wvalid = 1'b0, prev_wready = 1'b0;
  logic        prev_arvalid = 1'b0, prev_arready = 1'b0;
  logic [31:0] prev_awaddr = 32'h0, prev_wdata = 32'h0, prev_araddr = 32'h0;
  logic [3:0]  prev_wstrb = 4'h0;

  initial begin
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00;
    m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
  end

  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      if (prev_awvalid && !prev_awready)
        chk("aw_hold", {31'h0, m_awvalid, m_awaddr}, {31'h0, 1'b1, prev_awaddr});
      if (prev_wvalid && !prev_wready)
        chk("w_hold", {27'h0, m_wvalid, m_wstrb, m_wdata}, {27'h0, 1'b1, prev_wstrb, prev_wdata});
      if (prev_arvalid && !prev_arready)
        chk("ar_hold", {31'h0, m_arvalid, m_araddr}, {31'h0, 1'b1, prev_araddr});
      if (m_bready)
        chk("bready_early", {62'h0, m_awvalid, m_wvalid}, 64'h0);
    end
    if (rst) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
      m_bvalid = 1'b0; m_rvalid = 1'b0;
    end else begin
      if (m_awvalid) begin m_awready = (aw_cnt == cfg_aw_wait); aw_cnt++; end
      else begin m_awready = 1'b0; aw_cnt = 0; end
      if (m_wvalid) begin m_wready = (w_cnt == cfg_w_wait); w_cnt++; end
      else begin m_wready = 1'b0; w_cnt = 0; end
      if (m_arvalid) begin m_arready = (ar_cnt == cfg_ar_wait); ar_cnt++; end
      else begin m_arready = 1'b0; ar_cnt = 0; end
      m_bvalid = m_bready && !cfg_b_hold;
      m_bresp  = m_bvalid ? cfg_bresp : 2'b00;
      m_rvalid = m_rready;
      m_rdata  = m_rvalid ? cfg_rdata : 32'h0;
      m_rresp  = m_rvalid ? cfg_rresp : 2'b00;
    end
    prev_rst     = rst;
    prev_awvalid = m_awvalid; prev_awready = m_awready; prev_awaddr = m_awaddr;
    prev_wvalid  = m_wvalid;  prev_wready  = m_wready;
    prev_wdata   = m_wdata;   prev_wstrb   = m_wstrb;
    prev_arvalid = m_arvalid; prev_arready = m_arready; prev_araddr = m_araddr;
  end

  // Presents a request at a negedge, returns at the negedge after it is accepted
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic push, input resp_t e);
    core_req_valid = 1'b1;
    core_req_we    = we;
    core_req_addr  = a;
    core_req_wdata = d;
    core_req_wstrb = s;
    if (push) exp_q.push_back(e);
    for (int i = 0; i < 50 && !core_req_ready; i++) @(negedge clk);
    if (!core_req_ready) chk("accept_timeout", 64'(core_req_ready), 64'h1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && dbg_state == 3'd0) done = 1'b1;
    end
    chk(name, 64'(done), 64'h1);
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    logic hit;
    hit = (dbg_state == st);
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = (dbg_state == st);
    end
    chk(name, 64'(hit), 64'h1);
  endtask

  logic [2:0] tr_state [9];
  logic       tr_ready [9];

  initial begin
    rst = 1'b1;
    core_req_valid = 1'b0; core_req_we = 1'b0;
    core_req_addr = 32'h0; core_req_wdata = 32'h0; core_req_wstrb = 4'h0;
    repeat (3) @(negedge clk);

    chk("rst_ready", 64'(core_req_ready), 64'h1);
    chk("rst_state", 64'(dbg_state), 64'h0);
    chk("rst_valids", {58'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, core_resp_valid}, 64'h0);
    chk("rst_addr", {m_awaddr, m_araddr}, 64'h0);
    chk("rst_wdata", {28'h0, m_wstrb, m_wdata}, 64'h0);
    chk("rst_resp", {29'h0, core_resp_is_write, core_resp_resp, core_resp_rdata}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write with an always-ready slave
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, '{is_write: 1'b1, rdata: 32'h0, resp: 2'b00});
    core_req_valid = 1'b0;
    chk("w1_valids", {62'h0, m_awvalid, m_wvalid}, 64'h3);
    chk("w1_awaddr", 64'(m_awaddr), 64'h10);
    chk("w1_wdata", {28'h0, m_wstrb, m_wdata}, {28'h0, 4'hF, 32'hDEADBEEF});
    chk("w1_prot_ready", {58'h0, m_awprot, m_arprot}, 64'h0);
    chk("w1_req_ready_low", 64'(core_req_ready), 64'h0);
    @(negedge clk);
    chk("w1_wresp_state", {60'h0, m_bready, dbg_state}, {60'h0, 1'b1, 3'd2});
    @(negedge clk);
    chk("w1_resp_cycle", {60'h0, core_resp_valid, dbg_state}, {60'h0, 1'b1, 3'd5});
    wait_idle("w1_idle");

    // Split AW/W: awready three cycles late, wready immediate
    cfg_aw_wait = 3;
    issue(1'b1, 32'h44, 32'h01234567, 4'h3, 1'b1, '{is_write: 1'b1, rdata: 32'h0, resp: 2'b00});
    core_req_valid = 1'b0;
    chk("sp_c0", {61'h0, m_awvalid, m_wvalid, m_bready}, 64'h6);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("sp_c%0d", k), {61'h0, m_awvalid, m_wvalid, m_bready},
          (k < 4) ? 64'h4 : 64'h1);
    end
    wait_idle("sp_idle");
    cfg_aw_wait = 0;

    // Read with arready two cycles late
    cfg_ar_wait = 2; cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'b00;
    issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b1, '{is_write: 1'b0, rdata: 32'hCAFEF00D, resp: 2'b00});
    core_req_valid = 1'b0;
    chk("r1_ar", {31'h0, m_arvalid, m_araddr}, {31'h0, 1'b1, 32'h24});
    wait_idle("r1_idle");
    cfg_ar_wait = 0;

    // Error responses pass straight through
    cfg_bresp = 2'b10;
    issue(1'b1, 32'h80, 32'h55AA55AA, 4'h8, 1'b1, '{is_write: 1'b1, rdata: 32'h0, resp: 2'b10});
    core_req_valid = 1'b0;
    wait_idle("err_w_idle");
    cfg_bresp = 2'b00;
    cfg_rresp = 2'b11; cfg_rdata = 32'h12345678;
    issue(1'b0, 32'h84, 32'h0, 4'h0, 1'b1, '{is_write: 1'b0, rdata: 32'h12345678, resp: 2'b11});
    core_req_valid = 1'b0;
    wait_idle("err_r_idle");
    chk("err_ready", 64'(core_req_ready), 64'h1);
    cfg_rresp = 2'b00;

    // Back-to-back write then read with valid held high
    cfg_rdata = 32'hA5A55A5A;
    core_req_valid = 1'b1; core_req_we = 1'b1; core_req_addr = 32'h100;
    core_req_wdata = 32'h0BADF00D; core_req_wstrb = 4'hF;
    exp_q.push_back('{is_write: 1'b1, rdata: 32'h0, resp: 2'b00});
    for (int i = 0; i < 9; i++) begin
      tr_state[i] = dbg_state;
      tr_ready[i] = core_req_ready;
      if (i == 1) begin
        core_req_we = 1'b0; core_req_addr = 32'h200;
        exp_q.push_back('{is_write: 1'b0, rdata: 32'hA5A55A5A, resp: 2'b00});
      end
      if (i == 5) core_req_valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("b2b_state%0d", i), 64'(tr_state[i]), 64'(EXP_TR[i]));
      chk($sformatf("b2b_ready%0d", i), 64'(tr_ready[i]), 64'(EXP_RDY[i]));
    end
    wait_idle("b2b_idle");

    // Reset while waiting for B aborts without a response
    cfg_b_hold = 1'b1;
    issue(1'b1, 32'h300, 32'hFEEDFACE, 4'hF, 1'b0, '{is_write: 1'b0, rdata: 32'h0, resp: 2'b00});
    core_req_valid = 1'b0;
    wait_state(3'd2, "rm_reach_wresp");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg_b_hold = 1'b0;
    chk("rm_state", 64'(dbg_state), 64'h0);
    chk("rm_valids", {58'h0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, core_resp_valid}, 64'h0);
    chk("rm_ready", 64'(core_req_ready), 64'h1);
    @(negedge clk);
    cfg_rdata = 32'h00C0FFEE;
    issue(1'b0, 32'h304, 32'h0, 4'h0, 1'b1, '{is_write: 1'b0, rdata: 32'h00C0FFEE, resp: 2'b00});
    core_req_valid = 1'b0;
    wait_idle("rm_read_idle");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
